// File: rtl/regfile_wb_arb_if.sv
// Write-port arbiter bus: pipeline retire request, long-latency result push, flush and RF port.
// Optional WBARB_PERF_EN adds the two performance counter outputs.
interface regfile_wb_arb_if;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_reg;
    logic [31:0] ll_data;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ll_pending;
`ifdef WBARB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_ll_wr_cnt;
`endif

    modport master (
        output pipe_valid, pipe_reg, pipe_data, ll_valid, ll_reg, ll_data, flush,
        input  pipe_stall, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pending
`ifdef WBARB_PERF_EN
        , input perf_stall_cnt, perf_ll_wr_cnt
`endif
    );

    modport slave (
        input  pipe_valid, pipe_reg, pipe_data, ll_valid, ll_reg, ll_data, flush,
        output pipe_stall, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pending
`ifdef WBARB_PERF_EN
        , output perf_stall_cnt, perf_ll_wr_cnt
`endif
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter: pipeline has priority, long-latency results queue in a FIFO
// with a starvation bound. WBARB_PERF_EN adds stall / long-latency write counters.
module regfile_wb_arb #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic             clk_core,
    input logic             reset,
    regfile_wb_arb_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [4:0]      mem_reg  [DEPTH];
    logic [31:0]     mem_data [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [3:0]      starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [31:0]     rf_wdata_q, rf_wdata_d;
    logic            fifo_empty, fifo_full, ll_ready, push;
    logic            grant_pipe, grant_fifo, stall;
    logic [4:0]      head_reg;
    logic [31:0]     head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign ll_ready   = ~reset & ~fifo_full;
    assign push       = bus.ll_valid & ll_ready & ~bus.flush;
    assign head_reg   = mem_reg[rptr_q];
    assign head_data  = mem_data[rptr_q];

    // Grant is decided on registered FIFO state only; a fresh push never bypasses the FIFO.
    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
        stall      = 1'b0;
        if (!bus.flush) begin
            if (fifo_empty) begin
                grant_pipe = bus.pipe_valid;
            end else if (!bus.pipe_valid || starve_q == 4'(STARVE_MAX)) begin
                grant_fifo = 1'b1;
                stall      = bus.pipe_valid;
            end else begin
                grant_pipe = 1'b1;
            end
        end
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (bus.flush) begin
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            starve_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (grant_fifo) rptr_d = rptr_q + 1'b1;
            count_d = count_q + CntW'(push) - CntW'(grant_fifo);
            if (fifo_empty || grant_fifo) begin
                starve_d = '0;
            end else if (grant_pipe) begin
                starve_d = starve_q + 4'd1;
            end
            // x0 destinations are consumed without a write; address/data keep last real write
            if (grant_pipe && bus.pipe_reg != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.pipe_reg;
                rf_wdata_d = bus.pipe_data;
            end
            if (grant_fifo && head_reg != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = head_reg;
                rf_wdata_d = head_data;
            end
        end
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk_core) begin
        if (push) begin
            mem_reg[wptr_q]  <= bus.ll_reg;
            mem_data[wptr_q] <= bus.ll_data;
        end
    end

    assign bus.pipe_stall = stall & ~reset;
    assign bus.ll_ready   = ll_ready;
    assign bus.ll_pending = ~fifo_empty;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;

`ifdef WBARB_PERF_EN
    logic [31:0] perf_stall_q, perf_ll_wr_q;

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_ll_wr_q <= '0;
        end else begin
            if (stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (grant_fifo && head_reg != '0) perf_ll_wr_q <= perf_ll_wr_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_ll_wr_cnt = perf_ll_wr_q;
`endif
endmodule
